// File: rtl/tagged_btb.sv
// tagged_btb: set-associative, tagged branch target buffer with registered lookup,
// round-robin replacement and a sequential one-set-per-cycle flush.
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   flush_i              start invalidating every entry (ignored while a flush runs)
//   debug_mode_i         drops updates while high
//   vpc_i                fetch PC looked up this cycle, result appears next cycle
//   upd_valid_i          update strobe for upd_pc_i / upd_target_i
//   upd_pc_i             branch PC being trained
//   upd_target_i         resolved target for that branch
//   pred_valid_o         per-slot hit for the fetch block
//   pred_target_o        per-slot predicted target (zero when the slot misses)
//   flushing_o           high while the flush walks the sets
module tagged_btb #(
    parameter int NR_ENTRIES      = 64,
    parameter int NR_WAYS         = 4,
    parameter int TAG_BITS        = 8,
    parameter int INSTR_PER_FETCH = 2,
    parameter int VLEN            = 64
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic                                      debug_mode_i,
    input  logic [VLEN-1:0]                           vpc_i,
    input  logic                                      upd_valid_i,
    input  logic [VLEN-1:0]                           upd_pc_i,
    input  logic [VLEN-1:0]                           upd_target_i,
    output logic [INSTR_PER_FETCH-1:0]                pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0][VLEN-1:0]      pred_target_o,
    output logic                                      flushing_o
);
    localparam int NR_SETS   = NR_ENTRIES / NR_WAYS;
    localparam int SLOT_BITS = $clog2(INSTR_PER_FETCH);
    localparam int SET_BITS  = $clog2(NR_SETS);
    localparam int WAY_BITS  = $clog2(NR_WAYS);
    localparam int OFFSET    = 1;
    localparam int SET_LSB   = OFFSET + SLOT_BITS;
    localparam int TAG_LSB   = SET_LSB + SET_BITS;
    localparam int TAG_END   = TAG_LSB + TAG_BITS;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                 state_q, state_d;
    logic [SET_BITS-1:0]    cnt_q, cnt_d;

    logic                   valid_q  [NR_SETS][NR_WAYS];
    logic [TAG_BITS-1:0]    tag_q    [NR_SETS][NR_WAYS];
    logic [SLOT_BITS-1:0]   slot_q   [NR_SETS][NR_WAYS];
    logic [VLEN-1:0]        target_q [NR_SETS][NR_WAYS];
    logic [WAY_BITS-1:0]    ptr_q    [NR_SETS];

    logic [INSTR_PER_FETCH-1:0]           pred_valid_q, pred_valid_d;
    logic [INSTR_PER_FETCH-1:0][VLEN-1:0] pred_target_q, pred_target_d;

    logic [SET_BITS-1:0]  l_set, u_set;
    logic [TAG_BITS-1:0]  l_tag, u_tag;
    logic [SLOT_BITS-1:0] u_slot;
    logic                 upd_en, u_hit, u_free, blank;
    logic [WAY_BITS-1:0]  u_hit_way, u_free_way, wr_way;
    logic                 unused_ok;

    assign l_set  = vpc_i[SET_LSB +: SET_BITS];
    assign l_tag  = vpc_i[TAG_LSB +: TAG_BITS];
    assign u_slot = upd_pc_i[OFFSET +: SLOT_BITS];
    assign u_set  = upd_pc_i[SET_LSB +: SET_BITS];
    assign u_tag  = upd_pc_i[TAG_LSB +: TAG_BITS];
    assign unused_ok = ^{vpc_i[VLEN-1:TAG_END], vpc_i[OFFSET-1:0], vpc_i[OFFSET +: SLOT_BITS],
                         upd_pc_i[VLEN-1:TAG_END], upd_pc_i[OFFSET-1:0]};

    assign flushing_o    = state_q == FLUSH;
    assign upd_en        = upd_valid_i && !debug_mode_i && state_q == IDLE;
    assign pred_valid_o  = pred_valid_q;
    assign pred_target_o = pred_target_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == SET_BITS'(NR_SETS - 1)) ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Predictions are blanked from the edge that enters FLUSH through the edge
    // that leaves it, so no stale hit is visible during or right after a flush.
    assign blank = state_q == FLUSH || state_d == FLUSH;

    // Ways are scanned high to low so the lowest-indexed match is the last write.
    always_comb begin
        pred_valid_d  = '0;
        pred_target_d = '0;
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            for (int w = NR_WAYS - 1; w >= 0; w--) begin
                if (!blank && valid_q[l_set][w] && tag_q[l_set][w] == l_tag &&
                    slot_q[l_set][w] == SLOT_BITS'(s)) begin
                    pred_valid_d[s]  = 1'b1;
                    pred_target_d[s] = target_q[l_set][w];
                end
            end
        end
    end

    always_comb begin
        u_hit      = 1'b0;
        u_hit_way  = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (valid_q[u_set][w] && tag_q[u_set][w] == u_tag && slot_q[u_set][w] == u_slot) begin
                u_hit     = 1'b1;
                u_hit_way = WAY_BITS'(w);
            end
            if (!valid_q[u_set][w]) begin
                u_free     = 1'b1;
                u_free_way = WAY_BITS'(w);
            end
        end
        wr_way = u_hit ? u_hit_way : u_free ? u_free_way : ptr_q[u_set];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pred_valid_q  <= '0;
            pred_target_q <= '0;
            for (int i = 0; i < NR_SETS; i++) begin
                ptr_q[i] <= '0;
                for (int w = 0; w < NR_WAYS; w++) begin
                    valid_q[i][w]  <= 1'b0;
                    tag_q[i][w]    <= '0;
                    slot_q[i][w]   <= '0;
                    target_q[i][w] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pred_valid_q  <= pred_valid_d;
            pred_target_q <= pred_target_d;
            if (state_q == FLUSH) begin
                ptr_q[cnt_q] <= '0;
                for (int w = 0; w < NR_WAYS; w++) valid_q[cnt_q][w] <= 1'b0;
            end
            if (upd_en) begin
                valid_q[u_set][wr_way]  <= 1'b1;
                tag_q[u_set][wr_way]    <= u_tag;
                slot_q[u_set][wr_way]   <= u_slot;
                target_q[u_set][wr_way] <= upd_target_i;
                if (!u_hit && !u_free) ptr_q[u_set] <= ptr_q[u_set] + 1'b1;
            end
        end
    end
endmodule
